// File: rtl/ipmxb_qsgmii_hsst_rx_lane_rst_fsm.sv
// Per-lane QSGMII HSST RX reset sequencer: PMA reset, signal-detect qualification,
// CDR-lock wait and PCS reset, with link supervision and a saturating retry count.
module ipmxb_qsgmii_hsst_rx_lane_rst_fsm #(
    parameter int unsigned PMA_RST_CYCLES       = 200,
    parameter int unsigned SIGDET_STABLE_CYCLES = 1000,
    parameter int unsigned CDR_TIMEOUT_CYCLES   = 20000,
    parameter int unsigned PCS_RST_CYCLES       = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lane_rst,
    input  logic       i_pll_lock,
    input  logic       i_signal_loss,
    input  logic       i_cdr_align,
    input  logic       i_force_rst,
    output logic       o_rx_pma_rst,
    output logic       o_rx_pcs_rst,
    output logic       o_rx_rst_done,
    output logic [2:0] o_fsm_state,
    output logic [7:0] o_retry_cnt
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_PMA_RST     = 3'd1;
    localparam logic [2:0] ST_WAIT_SIGDET = 3'd2;
    localparam logic [2:0] ST_WAIT_CDR    = 3'd3;
    localparam logic [2:0] ST_PCS_RST     = 3'd4;
    localparam logic [2:0] ST_DONE        = 3'd5;

    localparam logic [15:0] PMA_LAST    = 16'(PMA_RST_CYCLES - 1);
    localparam logic [15:0] SIGDET_LAST = 16'(SIGDET_STABLE_CYCLES - 1);
    localparam logic [15:0] CDR_LAST    = 16'(CDR_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] PCS_LAST    = 16'(PCS_RST_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] cnt;
    logic        restart;
    logic        retry_inc;
    logic        sig_loss_m, sig_loss_s;
    logic        cdr_m, cdr_s;
    logic        pma_nxt, pcs_nxt, done_nxt;

    // Loss-of-signal synchronizer idles at "lost" so nothing qualifies out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_loss_m <= 1'b1;
            sig_loss_s <= 1'b1;
            cdr_m      <= 1'b0;
            cdr_s      <= 1'b0;
        end else begin
            sig_loss_m <= i_signal_loss;
            sig_loss_s <= sig_loss_m;
            cdr_m      <= i_cdr_align;
            cdr_s      <= cdr_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            o_retry_cnt   <= '0;
            o_rx_pma_rst  <= 1'b1;
            o_rx_pcs_rst  <= 1'b1;
            o_rx_rst_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_rx_pma_rst  <= pma_nxt;
            o_rx_pcs_rst  <= pcs_nxt;
            o_rx_rst_done <= done_nxt;
            if (restart || (state_nxt != state))
                cnt <= '0;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
            if (retry_inc && (o_retry_cnt != 8'hFF))
                o_retry_cnt <= o_retry_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        retry_inc = 1'b0;
        if (i_lane_rst || !i_pll_lock) begin
            state_nxt = ST_IDLE;
        end else if (i_force_rst && (state != ST_IDLE)) begin
            state_nxt = ST_PMA_RST;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_PMA_RST;
                ST_PMA_RST: begin
                    if (cnt == PMA_LAST)
                        state_nxt = ST_WAIT_SIGDET;
                end
                ST_WAIT_SIGDET: begin
                    if (sig_loss_s)
                        restart = 1'b1;
                    else if (cnt == SIGDET_LAST)
                        state_nxt = ST_WAIT_CDR;
                end
                ST_WAIT_CDR: begin
                    if (cdr_s) begin
                        state_nxt = ST_PCS_RST;
                    end else if (sig_loss_s) begin
                        state_nxt = ST_WAIT_SIGDET;
                    end else if (cnt == CDR_LAST) begin
                        state_nxt = ST_PMA_RST;
                        retry_inc = 1'b1;
                    end
                end
                // Link loss wins over completion so DONE is never reported on a dead link.
                ST_PCS_RST: begin
                    if (sig_loss_s || !cdr_s) begin
                        state_nxt = ST_PMA_RST;
                        retry_inc = 1'b1;
                    end else if (cnt == PCS_LAST) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (sig_loss_s || !cdr_s) begin
                        state_nxt = ST_PMA_RST;
                        retry_inc = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        pma_nxt  = 1'b0;
        pcs_nxt  = 1'b1;
        done_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE, ST_PMA_RST: pma_nxt = 1'b1;
            ST_DONE: begin
                pcs_nxt  = 1'b0;
                done_nxt = 1'b1;
            end
            ST_WAIT_SIGDET, ST_WAIT_CDR, ST_PCS_RST: pma_nxt = 1'b0;
            default: pma_nxt = 1'b1;
        endcase
    end

    assign o_fsm_state = state;

endmodule

// File: tb/tb_ipmxb_qsgmii_hsst_rx_lane_rst_fsm.sv
// Scoreboard bench: stimulus pushes model predictions per clock, a monitor pops and compares.
module tb_ipmxb_qsgmii_hsst_rx_lane_rst_fsm;

    localparam int PMA_N = 4, SIG_N = 8, CDR_N = 16, PCS_N = 4;

    logic clk = 1'b0;
    logic rst, lane_rst, pll_lock, signal_loss, cdr_align, force_rst;
    logic pma, pcs, done;
    logic [2:0] fsm_state;
    logic [7:0] retry;

    int n_checks = 0;
    int n_errors = 0;

    ipmxb_qsgmii_hsst_rx_lane_rst_fsm #(
        .PMA_RST_CYCLES(PMA_N), .SIGDET_STABLE_CYCLES(SIG_N),
        .CDR_TIMEOUT_CYCLES(CDR_N), .PCS_RST_CYCLES(PCS_N)
    ) dut (
        .clk(clk), .rst(rst), .i_lane_rst(lane_rst), .i_pll_lock(pll_lock),
        .i_signal_loss(signal_loss), .i_cdr_align(cdr_align), .i_force_rst(force_rst),
        .o_rx_pma_rst(pma), .o_rx_pcs_rst(pcs), .o_rx_rst_done(done),
        .o_fsm_state(fsm_state), .o_retry_cnt(retry)
    );

    always #5 clk = ~clk;

    // Reference model: state names as integers, sync pins kept as a two-deep history.
    int m_state, m_cnt, m_retry;
    bit sl_h1, sl_h2, cd_h1, cd_h2;
    logic [13:0] exp_q[$];

    function automatic logic [13:0] expect_vec();
        bit p, c, d;
        p = (m_state == 0 || m_state == 1);
        c = (m_state != 5);
        d = (m_state == 5);
        return {3'(m_state), p, c, d, 8'(m_retry)};
    endfunction

    task automatic model_step();
        int nst;
        bit again, bump, lost, locked;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_retry = 0;
            sl_h1 = 1; sl_h2 = 1; cd_h1 = 0; cd_h2 = 0;
        end else begin
            nst = m_state; again = 0; bump = 0;
            lost = sl_h2; locked = cd_h2;
            if (lane_rst || !pll_lock) nst = 0;
            else if (force_rst && m_state != 0) begin nst = 1; again = 1; end
            else if (m_state == 0) nst = 1;
            else if (m_state == 1) begin if (m_cnt == PMA_N - 1) nst = 2; end
            else if (m_state == 2) begin
                if (lost) again = 1;
                else if (m_cnt == SIG_N - 1) nst = 3;
            end else if (m_state == 3) begin
                if (locked) nst = 4;
                else if (lost) nst = 2;
                else if (m_cnt == CDR_N - 1) begin nst = 1; bump = 1; end
            end else if (m_state == 4) begin
                if (lost || !locked) begin nst = 1; bump = 1; end
                else if (m_cnt == PCS_N - 1) nst = 5;
            end else if (m_state == 5) begin
                if (lost || !locked) begin nst = 1; bump = 1; end
            end else nst = 0;
            if (again || nst != m_state) m_cnt = 0;
            else if (m_cnt < 65535) m_cnt++;
            m_state = nst;
            if (bump && m_retry < 255) m_retry++;
            sl_h2 = sl_h1; sl_h1 = signal_loss;
            cd_h2 = cd_h1; cd_h1 = cdr_align;
        end
    endtask

    task automatic tick();
        model_step();
        exp_q.push_back(expect_vec());
        @(negedge clk);
    endtask

    task automatic drive(input bit lr, input bit pl, input bit sl, input bit cd, input bit fr);
        lane_rst = lr; pll_lock = pl; signal_loss = sl; cdr_align = cd; force_rst = fr;
    endtask

    task automatic check_const(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic run_until_state(input int target, input int budget);
        int k;
        k = 0;
        while (m_state != target && k < budget) begin tick(); k++; end
        n_checks++;
        if (m_state != target) begin
            n_errors++;
            $display("FAIL reach_state_%0d: got model state %0d expected %0d", target, m_state, target);
        end
    endtask

    always @(posedge clk) begin
        logic [13:0] e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {fsm_state, pma, pcs, done, retry};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t: got st=%0d pma=%b pcs=%b done=%b retry=%0d, expected st=%0d pma=%b pcs=%b done=%b retry=%0d",
                         $time, a[13:11], a[10], a[9], a[8], a[7:0], e[13:11], e[10], e[9], e[8], e[7:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1, 0, 1, 0, 0);
        repeat (3) tick();
        check_const("reset_outputs", {1'b0, pma, pcs, done, retry}, {1'b0, 3'b110, 8'd0});
        rst = 1'b0;

        // Nominal bring-up to DONE
        drive(0, 1, 0, 1, 0);
        run_until_state(5, 60);
        repeat (5) tick();

        // CDR held low: repeated timeouts until the retry count saturates
        drive(0, 1, 0, 0, 0);
        repeat (300 * (PMA_N + SIG_N + CDR_N) + 100) tick();
        check_const("retry_saturated", {4'd0, retry}, {4'd0, 8'd255});

        // Fresh start, signal-detect glitch in WAIT_SIGDET
        rst = 1'b1; tick(); rst = 1'b0;
        drive(0, 1, 0, 1, 0);
        run_until_state(2, 20);
        repeat (5) tick();
        signal_loss = 1'b1; tick(); signal_loss = 1'b0;
        run_until_state(5, 60);

        // Link loss in DONE
        signal_loss = 1'b1; repeat (3) tick(); signal_loss = 1'b0;
        run_until_state(5, 60);

        // PLL loss during PCS reset
        cdr_align = 1'b0; repeat (4) tick(); cdr_align = 1'b1;
        run_until_state(4, 80);
        pll_lock = 1'b0; tick();
        check_const("abort_outputs", {1'b0, pma, pcs, done, 8'd0}, {1'b0, 3'b110, 8'd0});
        pll_lock = 1'b1;
        run_until_state(5, 60);

        // Force reset in DONE, then synchronous reset in DONE
        force_rst = 1'b1; repeat (3) tick(); force_rst = 1'b0;
        run_until_state(5, 60);
        rst = 1'b1; tick();
        check_const("rst_in_done", {1'b0, pma, pcs, done, retry}, {1'b0, 3'b110, 8'd0});
        rst = 1'b0;

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 149) == 0));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        @(posedge clk); #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
